// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: 4-wide fetch packet in, 4 oldest entries out.
// master = fetch register / decode side, slave = the queue itself.
interface fetch_queue_if;
  logic             flush;
  logic             in_valid;
  logic [3:0]       in_mask;
  logic [3:0][31:0] in_pc;
  logic [3:0][31:0] in_inst;
  logic [3:0]       in_hit;
  logic [3:0]       in_predict;
  logic [3:0][31:0] in_target;
  logic [3:0]       in_has_excp;
  logic [3:0][4:0]  in_excp_code;
  logic             stall_ifr;
  logic             out_ready;
  logic [3:0]       out_valid;
  logic [3:0][31:0] out_pc;
  logic [3:0][31:0] out_inst;
  logic [3:0]       out_hit;
  logic [3:0]       out_predict;
  logic [3:0][31:0] out_target;
  logic [3:0]       out_has_excp;
  logic [3:0][4:0]  out_excp_code;

  modport master (
    output flush, in_valid, in_mask, in_pc, in_inst, in_hit, in_predict,
           in_target, in_has_excp, in_excp_code, out_ready,
    input  stall_ifr, out_valid, out_pc, out_inst, out_hit, out_predict,
           out_target, out_has_excp, out_excp_code
  );

  modport slave (
    input  flush, in_valid, in_mask, in_pc, in_inst, in_hit, in_predict,
           in_target, in_has_excp, in_excp_code, out_ready,
    output stall_ifr, out_valid, out_pc, out_inst, out_hit, out_predict,
           out_target, out_has_excp, out_excp_code
  );
endinterface

// File: rtl/fetch_queue.sv
// Compacting circular instruction queue between fetch and decode.
// Optional FETCH_QUEUE_PERF_EN adds full/empty cycle counters.
module fetch_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave q
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]  perf_full_cycles,
  output logic [31:0]  perf_empty_cycles
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        hit;
    logic        predict;
    logic [31:0] target;
    logic        has_excp;
    logic [4:0]  excp_code;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           out_q [LANES];
  entry_t           out_d [LANES];
  entry_t           in_ent [LANES];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic [3:0]       valid_q, valid_d;
  logic             enq, deq;
  logic [2:0]       n_in, n_out, off;

  // Next-state: compaction write, pointer/count update, registered output view.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n_in    = '0;
    n_out   = '0;
    off     = '0;
    enq     = q.in_valid & ~stall_q & ~q.flush;
    deq     = q.out_ready & ~q.flush;

    for (int k = 0; k < LANES; k++) begin
      in_ent[k] = '{pc: q.in_pc[k], inst: q.in_inst[k], hit: q.in_hit[k],
                    predict: q.in_predict[k], target: q.in_target[k],
                    has_excp: q.in_has_excp[k], excp_code: q.in_excp_code[k]};
      if (enq && q.in_mask[k]) begin
        mem_d[PTR_W'(tail_q + PTR_W'(off))] = in_ent[k];
        off = off + 3'd1;
      end
    end
    n_in = off;

    if (deq) n_out = (count_q >= CNT_W'(LANES)) ? 3'(LANES) : 3'(count_q);

    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      tail_d  = tail_q + PTR_W'(n_in);
      head_d  = head_q + PTR_W'(n_out);
      count_d = count_q + CNT_W'(n_in) - CNT_W'(n_out);
    end

    // Outputs are registered copies of what the next state will present.
    for (int k = 0; k < LANES; k++) begin
      valid_d[k] = count_d > CNT_W'(k);
      out_d[k]   = mem_d[PTR_W'(head_d + PTR_W'(k))];
    end
    stall_d = count_d > CNT_W'(DEPTH - LANES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int k = 0; k < LANES; k++) out_q[k] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    q.stall_ifr = stall_q;
    q.out_valid = valid_q;
    for (int k = 0; k < LANES; k++) begin
      q.out_pc[k]        = out_q[k].pc;
      q.out_inst[k]      = out_q[k].inst;
      q.out_hit[k]       = out_q[k].hit;
      q.out_predict[k]   = out_q[k].predict;
      q.out_target[k]    = out_q[k].target;
      q.out_has_excp[k]  = out_q[k].has_excp;
      q.out_excp_code[k] = out_q[k].excp_code;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_full_q, perf_full_d, perf_empty_q, perf_empty_d;

  // Occupancy counters survive flush; only reset clears them.
  always_comb begin
    perf_full_d  = perf_full_q + 32'(stall_q);
    perf_empty_d = perf_empty_q + 32'(count_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_empty_q <= perf_empty_d;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic checked
// against a queue-based model of the fetch queue.
module tb_fetch_queue;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        hit;
    logic        predict;
    logic [31:0] target;
    logic        has_excp;
    logic [4:0]  excp_code;
  } ent_t;

  logic clk;
  logic rst;
  fetch_queue_if ifc ();
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_full, perf_empty;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_full_cycles  (perf_full),
    .perf_empty_cycles (perf_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;
  ent_t mq[$];
  int   m_full   = 0;
  int   m_empty  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ent_t in_slot(int k);
    return '{pc: ifc.in_pc[k], inst: ifc.in_inst[k], hit: ifc.in_hit[k],
             predict: ifc.in_predict[k], target: ifc.in_target[k],
             has_excp: ifc.in_has_excp[k], excp_code: ifc.in_excp_code[k]};
  endfunction

  function automatic ent_t out_slot(int k);
    return '{pc: ifc.out_pc[k], inst: ifc.out_inst[k], hit: ifc.out_hit[k],
             predict: ifc.out_predict[k], target: ifc.out_target[k],
             has_excp: ifc.out_has_excp[k], excp_code: ifc.out_excp_code[k]};
  endfunction

  task automatic set_in(input bit v, input logic [3:0] m, input bit rdy, input bit fl,
                        input logic [31:0] base);
    ifc.in_valid  = v;
    ifc.in_mask   = m;
    ifc.out_ready = rdy;
    ifc.flush     = fl;
    for (int k = 0; k < 4; k++) begin
      ifc.in_pc[k]        = base + 32'(4 * k);
      ifc.in_inst[k]      = $urandom;
      ifc.in_hit[k]       = 1'($urandom);
      ifc.in_predict[k]   = 1'($urandom);
      ifc.in_target[k]    = $urandom;
      ifc.in_has_excp[k]  = 1'($urandom);
      ifc.in_excp_code[k] = 5'($urandom);
    end
  endtask

  // Advance one clock: model applies the same inputs the DUT sees at the edge.
  task automatic cycle();
    ent_t nq[$];
    bit   stall;
    int   nout;
    stall = (DEPTH - mq.size()) < 4;
    nq    = mq;
    if (ifc.flush) nq.delete();
    else begin
      if (ifc.out_ready) begin
        nout = (mq.size() < 4) ? mq.size() : 4;
        repeat (nout) void'(nq.pop_front());
      end
      if (ifc.in_valid && !stall)
        for (int k = 0; k < 4; k++) if (ifc.in_mask[k]) nq.push_back(in_slot(k));
    end
    @(posedge clk);
    #1;
    mq = nq;
    if (stall) m_full++;
    if (nq.size() >= 0 && stall == stall) begin end
  endtask

  // Empty-cycle counter tracks the pre-edge occupancy, sampled each edge.
  always @(posedge clk) if (rst) if (mq.size() == 0) m_empty <= m_empty + 1;

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int         sz;
      logic [3:0] ev;
      sz = mq.size();
      for (int k = 0; k < 4; k++) ev[k] = sz > k;
      check("out_valid", ifc.out_valid, ev);
      check("stall_ifr", ifc.stall_ifr, (DEPTH - sz) < 4);
      for (int k = 0; k < 4; k++)
        if (k < sz) check($sformatf("payload%0d", k), out_slot(k), mq[k]);
`ifdef FETCH_QUEUE_PERF_EN
      check("perf_full", perf_full, 32'(m_full));
      check("perf_empty", perf_empty, 32'(m_empty));
`endif
    end
  end

  initial begin
    int thr;
    rst = 1'b0;
    set_in(0, 4'h0, 0, 0, 32'h0);

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ifc.out_valid, 4'b0000);
    check("rst_stall", ifc.stall_ifr, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_pc%0d", k), ifc.out_pc[k], 32'h0);
    rst = 1'b1;
    cycle();
    check("idle_valid", ifc.out_valid, 4'b0000);
    check("idle_stall", ifc.stall_ifr, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("idle_pc%0d", k), ifc.out_pc[k], 32'h0);
    chk_en = 1'b1;

    // Compaction
    set_in(1, 4'b1010, 0, 0, 32'h1000);
    cycle();
    check("cmp_valid", ifc.out_valid, 4'b0011);
    check("cmp_pc0", ifc.out_pc[0], 32'h1004);
    check("cmp_pc1", ifc.out_pc[1], 32'h100C);
    set_in(0, 4'h0, 0, 1, 32'h0);
    cycle();

    // Fill until stalled, fifth packet held off, one dequeue relieves
    for (int i = 0; i < 4; i++) begin
      set_in(1, 4'hF, 0, 0, 32'h2000 + 32'(16 * i));
      cycle();
    end
    check("fill_stall", ifc.stall_ifr, 1'b1);
    check("fill_model_cnt", 32'(mq.size()), 32'd16);
    set_in(1, 4'hF, 0, 0, 32'h3000);
    cycle();
    check("held_model_cnt", 32'(mq.size()), 32'd16);
    check("held_pc0", ifc.out_pc[0], 32'h2000);
    set_in(0, 4'h0, 1, 0, 32'h0);
    cycle();
    check("drain_stall", ifc.stall_ifr, 1'b0);
    check("drain_pc0", ifc.out_pc[0], 32'h2010);
    check("drain_model_cnt", 32'(mq.size()), 32'd12);
    set_in(0, 4'h0, 0, 1, 32'h0);
    cycle();

    // Wrap: count 14 from head 0, dequeue 4, enqueue 4 at tail 14
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4'hF, 0, 0, 32'h4000 + 32'(16 * i));
      cycle();
    end
    set_in(1, 4'b0011, 0, 0, 32'h4030);
    cycle();
    set_in(0, 4'h0, 1, 0, 32'h0);
    cycle();
    check("wrap_pc0", ifc.out_pc[0], 32'h4010);
    set_in(1, 4'hF, 0, 0, 32'h5000);
    cycle();
    check("wrap_stall", ifc.stall_ifr, 1'b1);
    set_in(0, 4'h0, 1, 0, 32'h0);
    cycle();
    cycle();
    check("wrap_pc2", ifc.out_pc[2], 32'h5000);
    check("wrap_pc3", ifc.out_pc[3], 32'h5004);
    cycle();
    check("wrap_valid", ifc.out_valid, 4'b0011);
    check("wrap_pc0b", ifc.out_pc[0], 32'h5008);
    check("wrap_pc1b", ifc.out_pc[1], 32'h500C);
    cycle();

    // Simultaneous enqueue and dequeue
    set_in(1, 4'b0111, 0, 0, 32'h6000);
    cycle();
    set_in(1, 4'hF, 1, 0, 32'h7000);
    cycle();
    check("sim_valid", ifc.out_valid, 4'b1111);
    check("sim_pc0", ifc.out_pc[0], 32'h7000);
    check("sim_stall", ifc.stall_ifr, 1'b0);

    // Flush beats enqueue and dequeue
    set_in(1, 4'hF, 0, 0, 32'h8000);
    cycle();
    set_in(1, 4'hF, 1, 1, 32'h9000);
    cycle();
    check("flush_valid", ifc.out_valid, 4'b0000);
    check("flush_stall", ifc.stall_ifr, 1'b0);

    // Random traffic with alternating drain pressure
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 200) % 2 == 1) ? 6 : 2;
      set_in($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) < thr,
             $urandom_range(0, 31) == 0, $urandom & 32'hFFFF_FFFC);
      cycle();
    end

    // Reset in the middle of traffic
    set_in(1, 4'hF, 0, 0, 32'hA000);
    cycle();
    chk_en = 1'b0;
    set_in(0, 4'h0, 0, 0, 32'h0);
    rst = 1'b0;
    #1;
    check("mrst_valid", ifc.out_valid, 4'b0000);
    check("mrst_stall", ifc.stall_ifr, 1'b0);
    check("mrst_pc0", ifc.out_pc[0], 32'h0);
    mq.delete();
    m_full  = 0;
    m_empty = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch-stage pipeline register and decode. Each cycle it accepts one 4-wide fetch packet (PC, instruction word, BTB hit/predict/target, exception tag per slot) and compacts the valid slots into a circular buffer. It presents up to 4 oldest entries, in program order, to decode. Backpressure goes upstream as a stall that freezes the fetch register.

## Interface
- DEPTH, 16, queue entries; power of two, >= 8
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  redirect from backend; discards all contents
- in_valid  in  1  fetch register holds a packet (fetch register `hint`)
- in_mask  in  4  per-slot valid; slot 0 oldest
- in_pc / in_inst  in  32 x4  PC and instruction word per slot
- in_hit / in_predict  in  1 x4  BTB hit, predicted-taken per slot
- in_target  in  32 x4  predicted target per slot
- in_has_excp  in  1 x4  fetch exception flag per slot
- in_excp_code  in  5 x4  exception code per slot
- stall_ifr  out  1  upstream must hold its packet
- out_ready  in  1  decode accepts all presented slots this cycle
- out_valid  out  4  thermometer: slot k valid iff count > k
- out_pc, out_inst, out_hit, out_predict, out_target, out_has_excp, out_excp_code  out  x4  same widths as inputs; head-relative entries 0..3

## Operation
- Storage: DEPTH entries of {pc, inst, hit, predict, target, has_excp, excp_code}; head, tail pointers (PTR_W bits); count (PTR_W+1 bits).
- stall_ifr = (DEPTH - count) < 4, computed from registered count only. It is not relieved by a same-cycle dequeue.
- Enqueue fires when in_valid & !stall_ifr & !flush.
  - n_in = popcount(in_mask).
  - Set slots are written in ascending slot order to tail, tail+1, ...; clear slots are skipped (compaction).
  - tail += n_in mod DEPTH.
- Dequeue fires when out_ready & !flush.
  - n_out = min(count, 4).
  - head += n_out mod DEPTH.
- count_next = count + n_in - n_out. Enqueue and dequeue in the same cycle are both applied.
- Output slot k shows entry (head+k) mod DEPTH. Slots with out_valid[k]=0 carry don't-care payload.
- flush: head = tail = count = 0 next cycle. It overrides enqueue and dequeue in the same cycle. Storage is not cleared.
- in_valid=1 with in_mask=0: no-op.
- Reset (rst=0, async): head, tail, count = 0; all storage entries zeroed.
  - Outputs after reset: out_valid=0000, stall_ifr=0, all payload outputs 0.
  - Reset asserted mid-operation discards all contents immediately.

## Timing
- Enqueue-to-output latency: 1 cycle. A packet accepted at edge N appears on out_* after edge N.
- No combinational path from in_* or out_ready to any output. All outputs are functions of registered state.
- stall_ifr asserts in the cycle after count rises above DEPTH-4. It deasserts in the cycle after a dequeue brings count to DEPTH-4 or less.
- Flush takes effect at the next edge: out_valid=0000 and stall_ifr=0 in the following cycle.
- Pointer wrap: an enqueue straddling index DEPTH-1 → 0 is written contiguously modulo DEPTH. Dequeue across the wrap behaves the same.
- Full (count=DEPTH) and empty (count=0) are distinguished by count, not by pointer equality.

## Configuration
- FETCH_QUEUE_PERF_EN defined:
  - Adds outputs perf_full_cycles (32) and perf_empty_cycles (32), each reset to 0 and cleared by rst only (not flush).
  - perf_full_cycles increments each cycle stall_ifr=1.
  - perf_empty_cycles increments each cycle count=0.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then idle: out_valid=0000, stall_ifr=0, out_pc[0..3]=0 during and after rst low.
- Compaction: in_mask=1010, in_pc={0x1000,0x1004,0x1008,0x100C}, out_ready=0 → next cycle out_valid=0011, out_pc[0]=0x1004, out_pc[1]=0x100C.
- Fill/stall (DEPTH=16, out_ready=0): four full packets → count=16, stall_ifr=1; fifth packet held off. Next, out_ready=1 for one cycle → count=12, stall_ifr=0 the following cycle.
- Wrap: count=14 from head=0, dequeue 4, then enqueue 4 with tail=14 → entries land at indices 14,15,0,1; drained order matches PCs.
- Simultaneous: count=3, enqueue 4 and out_ready=1 in the same cycle → count=4 next cycle, out_pc[0] = first new PC.
- Flush with enqueue and dequeue active → next cycle out_valid=0000, stall_ifr=0, head=tail=0. With FETCH_QUEUE_PERF_EN, perf counters are unchanged by the flush.
